// File: rtl/demux_1_to_4_if.sv
// demux_1_to_4_if
//   Stream bundle for the 1-to-4 demultiplexer: one producer-side input
//   stream and four consumer-side output channels.
//   Signals:
//     in_valid / in_ready / in_sel / in_data      producer handshake, destination, word
//     out_valid[3:0] / out_ready[3:0]             per-channel consumer handshake
//     out_data0..out_data3                        head word of each channel (0 when empty)
//   Modports:
//     slave  - the demultiplexer itself
//     master - the environment (producer plus the four consumers)
//   Macros: WORD_WIDTH (word width, defaults to 8 when not provided).

`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

interface demux_1_to_4_if #(
  parameter int WORD_WIDTH = `WORD_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_sel;
  logic [WORD_WIDTH-1:0] in_data;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [WORD_WIDTH-1:0] out_data0;
  logic [WORD_WIDTH-1:0] out_data1;
  logic [WORD_WIDTH-1:0] out_data2;
  logic [WORD_WIDTH-1:0] out_data3;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux_1_to_4.sv
// demux_1_to_4
//   Registered 1-to-4 stream demultiplexer. Each input word is steered to the
//   channel named by in_sel and buffered in that channel's FIFO, so a stalled
//   consumer only blocks words addressed to it.
//   Ports:
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset (discards all buffered words)
//     bus            demux_1_to_4_if.slave stream bundle
//     stat_clr       synchronous clear of the delivery counters
//     stat_cnt0..3   words delivered per channel (saturating)
//   Parameters: WORD_WIDTH, DEPTH (power of 2, >=2), CNT_WIDTH.
//   Macros:
//     DEMUX_STATS_EN - builds the per-channel delivery counters; when undefined
//                      stat_cnt* are tied to 0 and stat_clr is ignored.
//     WORD_WIDTH     - default word width (8 when not provided).

`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

module demux_1_to_4 #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1_to_4_if.slave        bus,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] stat_cnt0,
  output logic [CNT_WIDTH-1:0] stat_cnt1,
  output logic [CNT_WIDTH-1:0] stat_cnt2,
  output logic [CNT_WIDTH-1:0] stat_cnt3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WORD_WIDTH-1:0] r_mem   [4][DEPTH];
  logic [PW-1:0]         r_wptr  [4];
  logic [PW-1:0]         r_rptr  [4];
  logic [CW-1:0]         r_count [4];

  logic                  w_in_ready;
  logic [3:0]            w_valid;
  logic [3:0]            w_push;
  logic [3:0]            w_pop;
  logic [WORD_WIDTH-1:0] w_head  [4];

  // in_ready looks only at stored occupancy: a full channel refuses a word
  // even when its consumer is popping in the same cycle.
  always_comb begin
    w_in_ready = (r_count[bus.in_sel] != CW'(DEPTH));
    w_valid    = '0;
    w_push     = '0;
    w_pop      = '0;
    for (int k = 0; k < 4; k++) begin
      w_valid[k] = (r_count[k] != '0);
      w_push[k]  = bus.in_valid && w_in_ready && (bus.in_sel == 2'(k));
      w_pop[k]   = w_valid[k] && bus.out_ready[k];
      w_head[k]  = w_valid[k] ? r_mem[k][r_rptr[k]] : '0;
    end
  end

  // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + 1'b1;
          2'b01:   r_count[k] <= r_count[k] - 1'b1;
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // Storage needs no reset: an empty channel forces its out_data to 0.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_push[k]) r_mem[k][r_wptr[k]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data0 = w_head[0];
  assign bus.out_data1 = w_head[1];
  assign bus.out_data2 = w_head[2];
  assign bus.out_data3 = w_head[3];

`ifdef DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] r_stat [4];

  // Clear has priority over a same-cycle pop; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_stat[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (stat_clr)                            r_stat[k] <= '0;
        else if (w_pop[k] && (r_stat[k] != '1))  r_stat[k] <= r_stat[k] + 1'b1;
      end
    end
  end

  assign stat_cnt0 = r_stat[0];
  assign stat_cnt1 = r_stat[1];
  assign stat_cnt2 = r_stat[2];
  assign stat_cnt3 = r_stat[3];
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;

  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
  assign stat_cnt2 = '0;
  assign stat_cnt3 = '0;
`endif

endmodule

// File: tb/tb_demux_1_to_4.sv
// tb_demux_1_to_4
//   Bench for demux_1_to_4: directed scenarios followed by random traffic,
//   all compared against per-channel queue models of the expected behaviour.
//   Honours DEMUX_STATS_EN for the delivery counter expectations.

`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

module tb_demux_1_to_4;

  localparam int WW    = `WORD_WIDTH;
  localparam int DEPTH = 2;
  localparam int CW    = 3;
  localparam int SAT   = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  logic stat_clr;
  logic [CW-1:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;

  demux_1_to_4_if #(.WORD_WIDTH(WW)) bus ();

  demux_1_to_4 #(
    .WORD_WIDTH (WW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stat_clr  (stat_clr),
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_cnt3 (stat_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one queue per channel plus delivered-word counts.
  logic [WW-1:0] q [4][$];
  int            stat_m [4];

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] dout(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic [CW-1:0] scnt(input int k);
    case (k)
      0:       return stat_cnt0;
      1:       return stat_cnt1;
      2:       return stat_cnt2;
      default: return stat_cnt3;
    endcase
  endfunction

  task automatic check_outputs();
    logic [WW-1:0] exp_d;
    chk("in_ready", 32'(bus.in_ready), 32'(q[bus.in_sel].size() != DEPTH));
    for (int k = 0; k < 4; k++) begin
      exp_d = (q[k].size() != 0) ? q[k][0] : '0;
      chk($sformatf("out_valid%0d", k), 32'(bus.out_valid[k]), 32'(q[k].size() != 0));
      chk($sformatf("out_data%0d", k), 32'(dout(k)), 32'(exp_d));
`ifdef DEMUX_STATS_EN
      chk($sformatf("stat_cnt%0d", k), 32'(scnt(k)), 32'(stat_m[k]));
`else
      chk($sformatf("stat_cnt%0d", k), 32'(scnt(k)), 32'd0);
`endif
    end
  endtask

  // Drive one cycle of stimulus after the falling edge, check, then advance
  // the model across the rising edge.
  task automatic cycle(input logic iv, input logic [1:0] sel, input logic [WW-1:0] d,
                       input logic [3:0] ordy, input logic clr);
    logic       acc;
    logic [3:0] pop;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    stat_clr      = clr;
    #1;
    check_outputs();
    acc = iv && (q[sel].size() != DEPTH);
    for (int k = 0; k < 4; k++) pop[k] = ordy[k] && (q[k].size() != 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (pop[k]) void'(q[k].pop_front());
      if (clr)         stat_m[k] = 0;
      else if (pop[k]) stat_m[k] = (stat_m[k] >= SAT) ? SAT : stat_m[k] + 1;
    end
    if (acc) q[sel].push_back(d);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      stat_m[k] = 0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    stat_clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data2", 32'(bus.out_data2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word to channel 2, popped on the following edge.
    cycle(1'b1, 2'd2, WW'(8'hA5), 4'b0100, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'b0100);
    chk("t1_data2", 32'(bus.out_data2), 32'h00A5);
    cycle(1'b0, 2'd0, '0, 4'b0100, 1'b0);
    chk("t1_drained", 32'(bus.out_valid), 32'd0);

    // Channel 1 fills and stalls; channel 0 still accepts.
    cycle(1'b1, 2'd1, WW'(1), 4'b0000, 1'b0);
    cycle(1'b1, 2'd1, WW'(2), 4'b0000, 1'b0);
    bus.in_sel = 2'd1;
    #1;
    chk("t2_ready_sel1", 32'(bus.in_ready), 32'd0);
    bus.in_sel = 2'd0;
    #1;
    chk("t2_ready_sel0", 32'(bus.in_ready), 32'd1);
    cycle(1'b1, 2'd0, WW'(3), 4'b0000, 1'b0);
    chk("t2_valid", 32'(bus.out_valid), 32'b0011);
    cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0);
    cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0);
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // Full channel 3 refuses a push even while it pops.
    cycle(1'b1, 2'd3, WW'(7), 4'b0000, 1'b0);
    cycle(1'b1, 2'd3, WW'(8), 4'b0000, 1'b0);
    cycle(1'b1, 2'd3, WW'(9), 4'b1000, 1'b0);
    chk("t3_valid3", 32'(bus.out_valid[3]), 32'd1);
    chk("t3_data3", 32'(bus.out_data3), 32'd8);
    cycle(1'b0, 2'd0, '0, 4'b1000, 1'b0);
    chk("t3_count1", 32'(bus.out_valid[3]), 32'd0);

    // Simultaneous push and pop on channel 0 keeps order.
    cycle(1'b1, 2'd0, WW'(8'h11), 4'b0000, 1'b0);
    chk("t4_head11", 32'(bus.out_data0), 32'h11);
    cycle(1'b1, 2'd0, WW'(8'h22), 4'b0001, 1'b0);
    chk("t4_head22", 32'(bus.out_data0), 32'h22);
    chk("t4_valid0", 32'(bus.out_valid[0]), 32'd1);
    cycle(1'b0, 2'd0, '0, 4'b0001, 1'b0);
    chk("t4_drained", 32'(bus.out_valid), 32'd0);

    // Delivery counters: five pops on channel 1, then clear racing a pop.
    cycle(1'b0, 2'd0, '0, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'd1, WW'(i), 4'b0000, 1'b0);
      cycle(1'b0, 2'd1, '0, 4'b0010, 1'b0);
    end
`ifdef DEMUX_STATS_EN
    chk("t6_cnt1_5", 32'(stat_cnt1), 32'd5);
`else
    chk("t6_cnt1_off", 32'(stat_cnt1), 32'd0);
`endif
    cycle(1'b1, 2'd1, WW'(6), 4'b0000, 1'b0);
    cycle(1'b0, 2'd1, '0, 4'b0010, 1'b1);
    chk("t6_clr_wins", 32'(stat_cnt1), 32'd0);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 2'd1, WW'(i), 4'b0000, 1'b0);
      cycle(1'b0, 2'd1, '0, 4'b0010, 1'b0);
    end
`ifdef DEMUX_STATS_EN
    chk("t6_sat", 32'(stat_cnt1), 32'(SAT));
`else
    chk("t6_sat_off", 32'(stat_cnt1), 32'd0);
`endif

    // Fill every channel, then reset mid-cycle.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 2'(k), WW'(8'h40 + k), 4'b0000, 1'b0);
      cycle(1'b1, 2'(k), WW'(8'h50 + k), 4'b0000, 1'b0);
    end
    chk("t5_full", 32'(bus.out_valid), 32'hF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_data0", 32'(bus.out_data0), 32'd0);
    chk("t5_data3", 32'(bus.out_data3), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), WW'($urandom),
            4'($urandom), 1'($urandom_range(0, 60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
